// File: rtl/mmult_seq_ctrl.sv
// Sequencer for one 3x3 8-bit mmult instance: fetches A and B from a byte memory,
// clears and steps the multiplier, then streams the nine C elements over valid/ready.
module mmult_seq_ctrl #(
  parameter int ADDR_W     = 11,
  parameter int A_BASE     = 0,
  parameter int B_BASE     = 9,
  parameter int MM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              mm_rst_n,
  output logic              mm_enable,
  output logic [0:71]       mm_A,
  output logic [0:71]       mm_B,
  input  logic              mm_valid,
  input  logic [0:152]      mm_C,
  output logic              c_valid,
  input  logic              c_ready,
  output logic [16:0]       c_data,
  output logic [3:0]        c_idx
);

  localparam int TW = (MM_TIMEOUT < 2) ? 1 : $clog2(MM_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CLR,
    S_RUN,
    S_WAIT,
    S_SEND,
    S_FIN
  } state_t;

  state_t            state_q;
  logic [4:0]        k_q;
  logic [1:0]        run_q;
  logic [TW-1:0]     tmr_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic              mem_rd_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mm_rst_n_q;
  logic              mm_enable_q;
  logic [0:71]       mm_a_q;
  logic [0:71]       mm_b_q;
  logic              c_valid_q;
  logic [16:0]       c_data_q;
  logic [3:0]        c_idx_q;
  logic [16:0]       c_buf_q [9];
  logic [16:0]       mm_c_elem [9];

  logic [4:0]        k_d;
  logic [4:0]        cap_idx;
  logic [ADDR_W-1:0] addr_d;
  logic [3:0]        idx_d;

  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_c_unpack
      assign mm_c_elem[gi] = mm_C[gi*17 +: 17];
    end
  endgenerate

  // k_q counts issued reads; the byte arriving now belongs to the previous issue.
  assign k_d     = k_q + 5'd1;
  assign cap_idx = k_q - 5'd1;
  assign idx_d   = c_idx_q + 4'd1;

  always_comb begin
    addr_d = '0;
    if (k_d < 5'd9) begin
      addr_d = ADDR_W'(A_BASE) + ADDR_W'(k_d);
    end else if (k_d < 5'd18) begin
      addr_d = ADDR_W'(B_BASE) + ADDR_W'(k_d - 5'd9);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      run_q       <= '0;
      tmr_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= '0;
      mm_rst_n_q  <= 1'b1;
      mm_enable_q <= 1'b0;
      mm_a_q      <= '0;
      mm_b_q      <= '0;
      c_valid_q   <= 1'b0;
      c_data_q    <= '0;
      c_idx_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q    <= S_FETCH;
            busy_q     <= 1'b1;
            err_q      <= 1'b0;
            k_q        <= '0;
            mem_rd_q   <= 1'b1;
            mem_addr_q <= ADDR_W'(A_BASE);
          end
        end
        S_FETCH: begin
          if (k_q != 5'd0) begin
            if (cap_idx < 5'd9) begin
              mm_a_q[8*int'(cap_idx) +: 8] <= mem_rdata;
            end else begin
              mm_b_q[8*(int'(cap_idx) - 9) +: 8] <= mem_rdata;
            end
          end
          if (k_q == 5'd18) begin
            state_q    <= S_CLR;
            mm_rst_n_q <= 1'b0;
          end else begin
            k_q        <= k_d;
            mem_rd_q   <= (k_d < 5'd18);
            mem_addr_q <= addr_d;
          end
        end
        S_CLR: begin
          state_q     <= S_RUN;
          mm_rst_n_q  <= 1'b1;
          mm_enable_q <= 1'b1;
          run_q       <= '0;
          tmr_q       <= '0;
        end
        S_RUN: begin
          tmr_q <= tmr_q + TW'(1);
          run_q <= run_q + 2'd1;
          if (run_q == 2'd2) begin
            mm_enable_q <= 1'b0;
            state_q     <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Valid wins over a simultaneous timeout; MM_TIMEOUT is assumed >= 4.
          if (mm_valid) begin
            state_q   <= S_SEND;
            c_valid_q <= 1'b1;
            c_data_q  <= mm_c_elem[0];
            c_idx_q   <= '0;
          end else if (tmr_q == TW'(MM_TIMEOUT - 1)) begin
            state_q <= S_FIN;
            err_q   <= 1'b1;
            done_q  <= 1'b1;
          end else begin
            tmr_q <= tmr_q + TW'(1);
          end
        end
        S_SEND: begin
          if (c_ready) begin
            if (c_idx_q == 4'd8) begin
              c_valid_q <= 1'b0;
              done_q    <= 1'b1;
              state_q   <= S_FIN;
            end else begin
              c_idx_q  <= idx_d;
              c_data_q <= c_buf_q[idx_d];
            end
          end
        end
        S_FIN: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Snapshot of C taken once, so mmult may be cleared or rerun while elements drain.
  always_ff @(posedge clk) begin
    if (state_q == S_WAIT && mm_valid) begin
      for (int i = 0; i < 9; i++) begin
        c_buf_q[i] <= mm_c_elem[i];
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign mem_rd    = mem_rd_q;
  assign mem_addr  = mem_addr_q;
  assign mm_rst_n  = reset_n & mm_rst_n_q;
  assign mm_enable = mm_enable_q;
  assign mm_A      = mm_a_q;
  assign mm_B      = mm_b_q;
  assign c_valid   = c_valid_q;
  assign c_data    = c_data_q;
  assign c_idx     = c_idx_q;

endmodule

// File: tb/tb_mmult_seq_ctrl.sv
// Bench for mmult_seq_ctrl: byte memory, behavioural mmult, and a scoreboard of
// expected C elements computed from the matrices the bench loads.
module tb_mmult_seq_ctrl;

  localparam int ADDR_W     = 11;
  localparam int MM_TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              busy, done, err, mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic              mm_rst_n, mm_enable, mm_valid;
  logic [0:71]       mm_A, mm_B;
  logic [0:152]      mm_C;
  logic              c_valid;
  logic              c_ready = 1'b0;
  logic [16:0]       c_data;
  logic [3:0]        c_idx;

  always #5 clk = ~clk;

  mmult_seq_ctrl #(
    .ADDR_W(ADDR_W), .A_BASE(0), .B_BASE(9), .MM_TIMEOUT(MM_TIMEOUT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done), .err(err),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mm_rst_n(mm_rst_n), .mm_enable(mm_enable), .mm_A(mm_A), .mm_B(mm_B),
    .mm_valid(mm_valid), .mm_C(mm_C),
    .c_valid(c_valid), .c_ready(c_ready), .c_data(c_data), .c_idx(c_idx)
  );

  // Synchronous byte memory, one cycle read latency
  logic [7:0] mem [2048];
  always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

  // Behavioural mmult: one row per enabled cycle, sticky valid until mm_rst_n
  logic [1:0]   mdl_row;
  logic         mdl_valid;
  logic [0:152] mdl_c;
  logic         tie_valid_low = 1'b0;
  assign mm_valid = mdl_valid & ~tie_valid_low;
  assign mm_C     = mdl_c;

  function automatic logic [16:0] row_elem(input logic [0:71] a, input logic [0:71] b,
                                           input int r, input int j);
    int s;
    s = 0;
    for (int k = 0; k < 3; k++) s = s + int'(a[(r*3+k)*8 +: 8]) * int'(b[(k*3+j)*8 +: 8]);
    return 17'(s);
  endfunction

  always @(posedge clk) begin
    if (!mm_rst_n) begin
      mdl_row   <= 2'd0;
      mdl_valid <= 1'b0;
      mdl_c     <= '0;
    end else if (mm_enable && mdl_row < 2'd3) begin
      for (int j = 0; j < 3; j++)
        mdl_c[(int'(mdl_row)*3+j)*17 +: 17] <= row_elem(mm_A, mm_B, int'(mdl_row), j);
      mdl_row <= mdl_row + 2'd1;
      if (mdl_row == 2'd2) mdl_valid <= 1'b1;
    end
  end

  int checks = 0;
  int errors = 0;
  int a_m [9];
  int b_m [9];
  logic [20:0] exp_q [$];

  logic [ADDR_W-1:0] rd_addrs [$];
  int n_xfer, done_cnt, err_at_done, err_first, done_cyc, en_first, en_cnt, clr_cnt;
  int stable_err, hold_cnt, valid_seen, first_xfer, last_xfer, first_valid;
  bit hung;

  task automatic load_mem(input bit push);
    int s;
    for (int i = 0; i < 9; i++) begin
      mem[i]     = 8'(a_m[i]);
      mem[9 + i] = 8'(b_m[i]);
    end
    if (push) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) begin
          s = 0;
          for (int k = 0; k < 3; k++) s = s + a_m[i*3+k] * b_m[k*3+j];
          exp_q.push_back({4'(i*3+j), 17'(s)});
        end
    end
  endtask

  // Drives one start, observes until done plus a tail; elements are scored as they transfer.
  task automatic run_job(input int ready_mode, input bit restart, input int tail);
    int cyc;
    bit prev_hold;
    logic [16:0] hold_data;
    logic [3:0]  hold_idx;
    logic [20:0] e;
    rd_addrs.delete();
    n_xfer = 0; done_cnt = 0; err_at_done = 0; err_first = 0; done_cyc = -1; en_first = -1;
    en_cnt = 0; clr_cnt = 0; stable_err = 0; hold_cnt = 0; valid_seen = 0;
    first_xfer = -1; last_xfer = -1; first_valid = -1; hung = 0;
    prev_hold = 0; hold_data = '0; hold_idx = '0;
    @(negedge clk); start = 1'b1;
    cyc = 0;
    while (1) begin
      @(negedge clk);
      start   = restart && (cyc == 5 || (first_valid >= 0 && cyc == first_valid + 1) || done === 1'b1);
      c_ready = (ready_mode == 0) || (cyc % 2 == 1);
      if (cyc == 0) err_first = int'(err);
      if (mem_rd === 1'b1) rd_addrs.push_back(mem_addr);
      if (mm_rst_n === 1'b0) clr_cnt++;
      if (mm_enable === 1'b1) begin
        if (en_first < 0) en_first = cyc;
        en_cnt++;
      end
      if (prev_hold && (c_valid !== 1'b1 || c_data !== hold_data || c_idx !== hold_idx)) stable_err++;
      if (c_valid === 1'b1) begin
        valid_seen++;
        if (first_valid < 0) first_valid = cyc;
      end
      if (c_valid === 1'b1 && c_ready) begin
        n_xfer++;
        if (first_xfer < 0) first_xfer = cyc;
        last_xfer = cyc;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL element: got idx=%0d data=%0d, required no element", c_idx, c_data);
        end else begin
          e = exp_q.pop_front();
          if ({c_idx, c_data} !== e) begin
            errors++;
            $display("FAIL element: got idx=%0d data=%0d, required idx=%0d data=%0d",
                     c_idx, c_data, e[20:17], e[16:0]);
          end
        end
      end
      if (c_valid === 1'b1 && !c_ready) hold_cnt++;
      prev_hold = (c_valid === 1'b1) && !c_ready;
      hold_data = c_data;
      hold_idx  = c_idx;
      if (done === 1'b1) begin
        done_cnt++;
        err_at_done = int'(err);
        done_cyc = cyc;
      end
      cyc++;
      if (done_cyc >= 0 && cyc > done_cyc + tail) break;
      if (cyc >= 400) begin
        hung = 1;
        break;
      end
    end
    start   = 1'b0;
    c_ready = 1'b0;
    if (hung) begin
      checks++; errors++;
      $display("FAIL run_bound: no done within 400 cycles");
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, err, mem_rd, mm_enable, c_valid} !== 6'b0 || mem_addr !== '0 ||
        c_data !== '0 || c_idx !== '0 || mm_A !== '0 || mm_B !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b err=%b rd=%b en=%b cv=%b addr=%0d data=%0d idx=%0d, required all 0",
               busy, done, err, mem_rd, mm_enable, c_valid, mem_addr, c_data, c_idx);
    end
    checks++;
    if (mm_rst_n !== 1'b0) begin
      errors++;
      $display("FAIL reset_mm_rst_n: got %b, required 0", mm_rst_n);
    end
    reset_n = 1'b1;
    #1;
    checks++;
    if (mm_rst_n !== 1'b1) begin
      errors++;
      $display("FAIL release_mm_rst_n: got %b, required 1", mm_rst_n);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || mem_rd !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got busy=%b rd=%b, required 0 0", busy, mem_rd);
    end
    $display("test_reset done");
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 9; i++) begin a_m[i] = i + 3; b_m[i] = 9 - i; end
    load_mem(1'b0);
    tie_valid_low = 1'b1;
    run_job(0, 1'b0, 4);
    tie_valid_low = 1'b0;
    checks++;
    if (done_cnt !== 1 || err_at_done !== 1) begin
      errors++;
      $display("FAIL timeout_done: got done_cnt=%0d err=%0d, required 1 1", done_cnt, err_at_done);
    end
    checks++;
    if (done_cyc - en_first !== MM_TIMEOUT) begin
      errors++;
      $display("FAIL timeout_latency: got %0d cycles, required %0d", done_cyc - en_first, MM_TIMEOUT);
    end
    checks++;
    if (valid_seen !== 0) begin
      errors++;
      $display("FAIL timeout_no_output: got %0d valid cycles, required 0", valid_seen);
    end
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_err_held: got err=%b busy=%b, required 1 0", err, busy);
    end
    $display("test_timeout done: latency=%0d", done_cyc - en_first);
  endtask

  task automatic test_identity();
    for (int i = 0; i < 9; i++) begin a_m[i] = (i % 4 == 0) ? 1 : 0; b_m[i] = i + 1; end
    load_mem(1'b1);
    run_job(0, 1'b0, 3);
    checks++;
    if (n_xfer !== 9 || done_cnt !== 1 || err_at_done !== 0) begin
      errors++;
      $display("FAIL identity_run: got xfers=%0d done=%0d err=%0d, required 9 1 0", n_xfer, done_cnt, err_at_done);
    end
    checks++;
    if (err_first !== 0) begin
      errors++;
      $display("FAIL err_cleared_on_start: got %0d, required 0", err_first);
    end
    checks++;
    if (last_xfer - first_xfer !== 8) begin
      errors++;
      $display("FAIL ready_high_rate: got %0d cycles first-to-last, required 8", last_xfer - first_xfer);
    end
    checks++;
    if (clr_cnt !== 1 || en_cnt !== 3) begin
      errors++;
      $display("FAIL clr_run_pulses: got clr=%0d en=%0d, required 1 3", clr_cnt, en_cnt);
    end
    $display("test_identity done: xfers=%0d", n_xfer);
  endtask

  task automatic test_all255();
    for (int i = 0; i < 9; i++) begin a_m[i] = 255; b_m[i] = 255; end
    load_mem(1'b1);
    run_job(0, 1'b0, 3);
    checks++;
    if (n_xfer !== 9 || done_cnt !== 1 || err_at_done !== 0 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL all255_run: got xfers=%0d done=%0d err=%0d left=%0d, required 9 1 0 0",
               n_xfer, done_cnt, err_at_done, exp_q.size());
    end
    $display("test_all255 done: xfers=%0d", n_xfer);
  endtask

  task automatic test_ready_toggle();
    for (int i = 0; i < 9; i++) begin a_m[i] = i + 1; b_m[i] = (i % 4 == 0) ? 1 : 0; end
    load_mem(1'b1);
    run_job(1, 1'b0, 3);
    checks++;
    if (n_xfer !== 9 || done_cnt !== 1) begin
      errors++;
      $display("FAIL toggle_run: got xfers=%0d done=%0d, required 9 1", n_xfer, done_cnt);
    end
    checks++;
    if (stable_err !== 0 || hold_cnt < 8) begin
      errors++;
      $display("FAIL toggle_hold: got unstable=%0d holds=%0d, required 0 and >=8", stable_err, hold_cnt);
    end
    $display("test_ready_toggle done: holds=%0d", hold_cnt);
  endtask

  task automatic test_back_to_back();
    bit addr_ok;
    for (int i = 0; i < 9; i++) begin a_m[i] = int'($urandom_range(0, 255)); b_m[i] = int'($urandom_range(0, 255)); end
    load_mem(1'b1);
    run_job(0, 1'b1, 30);
    addr_ok = (rd_addrs.size() == 18);
    for (int i = 0; i < rd_addrs.size(); i++) if (rd_addrs[i] !== ADDR_W'(i)) addr_ok = 0;
    checks++;
    if (!addr_ok) begin
      errors++;
      $display("FAIL fetch_addrs: got %0d reads (first %0d), required 18 reads at 0..17",
               rd_addrs.size(), (rd_addrs.size() > 0) ? int'(rd_addrs[0]) : -1);
    end
    checks++;
    if (done_cnt !== 1 || n_xfer !== 9 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_run: got done=%0d xfers=%0d busy=%b, required 1 9 0", done_cnt, n_xfer, busy);
    end
    $display("test_back_to_back done: reads=%0d", rd_addrs.size());
  endtask

  task automatic test_reset_midrun();
    bit found;
    found = 0;
    for (int i = 0; i < 9; i++) begin a_m[i] = 10 + i; b_m[i] = 200 - i; end
    load_mem(1'b0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (mem_rd === 1'b1 && mem_addr == ADDR_W'(10)) found = 1;
      else @(negedge clk);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL midrun_reach_k10: got no read at address 10, required one within 40 cycles");
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, err, mem_rd, mm_enable, c_valid, mm_rst_n} !== 7'b0 || mem_addr !== '0 ||
        c_data !== '0 || c_idx !== '0 || mm_A !== '0 || mm_B !== '0) begin
      errors++;
      $display("FAIL midrun_reset_values: got busy=%b rd=%b addr=%0d mm_rst_n=%b mmA_nonzero=%b, required 0 0 0 0 0",
               busy, mem_rd, mem_addr, mm_rst_n, |mm_A);
    end
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || mem_rd !== 1'b0) begin
      errors++;
      $display("FAIL midrun_no_resume: got busy=%b rd=%b, required 0 0", busy, mem_rd);
    end
    for (int i = 0; i < 9; i++) begin a_m[i] = 3 * i + 1; b_m[i] = 17 * i + 5; end
    load_mem(1'b1);
    run_job(0, 1'b0, 3);
    checks++;
    if (n_xfer !== 9 || done_cnt !== 1 || err_at_done !== 0 || rd_addrs.size() !== 18) begin
      errors++;
      $display("FAIL midrun_rerun: got xfers=%0d done=%0d err=%0d reads=%0d, required 9 1 0 18",
               n_xfer, done_cnt, err_at_done, rd_addrs.size());
    end
    $display("test_reset_midrun done: xfers=%0d", n_xfer);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
    test_reset();
    test_timeout();
    test_identity();
    test_all255();
    test_ready_toggle();
    test_back_to_back();
    test_reset_midrun();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drained: got %0d pending, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
